// File: rtl/rs_pkg.sv
// Shared definitions for the parametrised serial receiver: FSM state
// encoding, parity mode codes, oversample ratio and divider helper.
package rs_pkg;

  localparam int OSR = 16;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rs_state_e;

  // clk50 cycles per oversample tick, rounded to nearest.
  function automatic int osr_div(input int clk_hz, input int baud);
    longint num;
    longint den;
    den = longint'(OSR) * longint'(baud);
    num = longint'(clk_hz) + den / 2;
    return int'(num / den);
  endfunction

endpackage

// File: rtl/rs_rx_fifo.sv
// Receive FIFO: power-of-two depth, head word presented combinationally,
// head reads as zero while empty. A push into a full FIFO is only
// accepted when a pop happens in the same cycle.
module rs_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk50,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  // storage write, no reset needed since head is masked while empty
  always_ff @(posedge clk50) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rs_rx_param.sv
// Parametrised asynchronous serial receiver with 16x oversampling,
// 3-sample majority voting, parity/framing checks and a receive FIFO.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | line idle, waiting for a synchronized falling edge
// ST_START     | validating the start bit (majority 1 = glitch, abort)
// ST_DATA      | shifting data bits LSB first
// ST_PARITY    | capturing the parity bit
// ST_STOP      | sampling stop bits, decides push / error at the last
// ST_WAIT_IDLE | framing error seen, waiting for the line to go high
module rs_rx_param
  import rs_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 1,
  parameter int STOP_BITS  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk50,
  input  logic                          rst_n,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV_RAW = osr_div(CLK_HZ, BAUD);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV - 1);

  rs_state_e state;
  rs_state_e state_nxt;

  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_prev;
  logic [1:0]           settle;
  logic                 armed;
  logic                 start_det;

  logic [DIV_W-1:0]     div_cnt;
  logic [3:0]           os_cnt;
  logic                 active;
  logic                 tick;
  logic                 bit_sample;
  logic                 samp7;
  logic                 samp8;
  logic                 maj;

  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 stop_bad;
  logic                 par_bit;
  logic [DATA_BITS-1:0] shreg;
  logic                 data_done;
  logic                 last_stop;

  logic                 frame_done;
  logic                 par_calc;
  logic                 par_bad;
  logic                 frm_bad;
  logic                 push;
  logic                 perr_d;
  logic                 ferr_d;

  logic                 fifo_full;
  logic                 fifo_empty;

  // Input synchronizer. Edge detection stays disarmed after reset until the
  // synchronized line has been seen high, so a line that is low at reset
  // release (mid-frame) is not mistaken for a new start bit.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      settle  <= 2'b00;
      armed   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      settle  <= {settle[0], 1'b1};
      if (settle[1] && rx_s) armed <= 1'b1;
    end
  end

  assign start_det  = armed & rx_prev & ~rx_s;
  assign active     = (state == ST_START) || (state == ST_DATA) ||
                      (state == ST_PARITY) || (state == ST_STOP);
  assign tick       = (div_cnt == '0);
  assign bit_sample = active && tick && (os_cnt == 4'd9);
  assign maj        = (samp7 & samp8) | (samp7 & rx_s) | (samp8 & rx_s);
  assign data_done  = (bit_cnt == 4'(DATA_BITS - 1));
  assign last_stop  = (STOP_BITS == 1) ? 1'b1 : stop_cnt;

  // Oversample divider (down-counter) and tick counter; held in reload
  // while idle so the first tick lands a full period after the start edge.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= DIV_RELOAD;
      os_cnt  <= 4'd0;
      samp7   <= 1'b1;
      samp8   <= 1'b1;
    end else if (!active) begin
      div_cnt <= DIV_RELOAD;
      os_cnt  <= 4'd0;
    end else if (tick) begin
      div_cnt <= DIV_RELOAD;
      os_cnt  <= os_cnt + 4'd1;
      if (os_cnt == 4'd7) samp7 <= rx_s;
      if (os_cnt == 4'd8) samp8 <= rx_s;
    end else begin
      div_cnt <= div_cnt - DIV_W'(1);
    end
  end

  // Frame datapath: bit counters, shift register, parity and stop capture.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= 4'd0;
      stop_cnt <= 1'b0;
      stop_bad <= 1'b0;
      par_bit  <= 1'b0;
      shreg    <= '0;
    end else if (bit_sample) begin
      case (state)
        ST_START: begin
          bit_cnt  <= 4'd0;
          stop_cnt <= 1'b0;
          stop_bad <= 1'b0;
        end
        ST_DATA: begin
          shreg   <= {maj, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
        ST_PARITY: par_bit <= maj;
        ST_STOP: begin
          stop_cnt <= 1'b1;
          stop_bad <= stop_bad | ~maj;
        end
        default: ;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic; decisions are taken at each bit's majority sample
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (start_det) state_nxt = ST_START;
      ST_START:
        if (bit_sample) state_nxt = maj ? ST_IDLE : ST_DATA;
      ST_DATA:
        if (bit_sample && data_done)
          state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY:
        if (bit_sample) state_nxt = ST_STOP;
      ST_STOP:
        if (bit_sample && last_stop)
          state_nxt = (stop_bad | ~maj) ? ST_WAIT_IDLE : ST_IDLE;
      ST_WAIT_IDLE:
        if (rx_s) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: frame verdict at the final stop-bit sample
  always_comb begin
    frame_done = 1'b0;
    par_calc   = ^shreg ^ par_bit;
    par_bad    = 1'b0;
    frm_bad    = stop_bad | ~maj;
    if (state == ST_STOP && bit_sample && last_stop) frame_done = 1'b1;
    if (PARITY == PAR_EVEN)     par_bad = par_calc;
    else if (PARITY == PAR_ODD) par_bad = ~par_calc;
    push   = frame_done & ~par_bad & ~frm_bad;
    perr_d = frame_done & par_bad;
    ferr_d = frame_done & frm_bad;
  end

  // Registered one-cycle status pulses
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= perr_d;
      frame_err  <= ferr_d;
      overrun    <= push & fifo_full & ~(rx_ready & rx_valid);
    end
  end

  rs_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk50     (clk50),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shreg),
    .pop       (rx_ready),
    .head      (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rx_valid = ~fifo_empty;

endmodule

// File: tb/tb_rs_rx_param.sv
// Bench for rs_rx_param with a fast clock ratio (4 clk50 cycles per
// oversample tick, 64 per bit) so full frames stay short.
module tb_rs_rx_param;

  localparam int CLK_HZ = 614400;
  localparam int BAUD   = 9600;
  localparam int BIT    = CLK_HZ / BAUD;

  logic       clk50;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic [2:0] fifo_count;

  rs_rx_param #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1),
    .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut (
    .clk50(clk50), .rst_n(rst_n), .rx(rx), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .parity_err(parity_err),
    .frame_err(frame_err), .overrun(overrun), .fifo_count(fifo_count)
  );

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  typedef struct {
    logic [7:0] data;
    bit         flip;
    bit [1:0]   stops;
    int         exp_count;
    int         exp_perr;
    int         exp_ferr;
    int         exp_both;
  } vec_t;

  vec_t       tbl [7];
  int         n_cmp, n_bad;
  int         perr_cnt, ferr_cnt, ovr_cnt, both_cnt;
  bit         rnd_mode;
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: count status pulses and, in random mode, act as consumer
  task automatic step();
    @(negedge clk50);
    if (parity_err === 1'b1) perr_cnt++;
    if (frame_err === 1'b1) ferr_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
    if (parity_err === 1'b1 && frame_err === 1'b1) both_cnt++;
    if (rnd_mode) begin
      if (rx_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rnd_unexpected: got word 0x%0h, expected none", rx_data);
        end else begin
          chk("rnd_data", 32'(rx_data), 32'(exp_q[0]));
        end
      end
      rx_ready = 1'($urandom_range(0, 1));
      if (rx_valid === 1'b1 && rx_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic idle(input int nbits);
    repeat (nbits * BIT) step();
  endtask

  task automatic clear_cnt();
    perr_cnt = 0; ferr_cnt = 0; ovr_cnt = 0; both_cnt = 0;
  endtask

  // Transmit one frame: start, 8 data LSB first, even parity (optionally
  // inverted), two stop bits; then line idles high or stays low.
  task automatic send_frame(input logic [7:0] d, input bit flip,
                            input bit [1:0] stops, input bit tail_low);
    logic [11:0] bits;
    bits = {stops[1], stops[0], (^d) ^ flip, d, 1'b0};
    for (int i = 0; i < 12; i++) begin
      rx = bits[i];
      repeat (BIT) step();
    end
    rx = tail_low ? 1'b0 : 1'b1;
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    step();
  endtask

  initial begin
    int exp_perr, exp_ferr, exp_both;
    int budget;
    n_cmp = 0; n_bad = 0; rnd_mode = 0;
    clear_cnt();
    rx = 1'b1; rx_ready = 1'b0; rst_n = 1'b0;

    tbl[0] = '{8'hA5, 0, 2'b11, 1, 0, 0, 0};
    tbl[1] = '{8'h5A, 1, 2'b11, 0, 1, 0, 0};
    tbl[2] = '{8'h3C, 0, 2'b01, 0, 0, 1, 0};
    tbl[3] = '{8'h81, 0, 2'b10, 0, 0, 1, 0};
    tbl[4] = '{8'h66, 1, 2'b00, 0, 1, 1, 1};
    tbl[5] = '{8'h00, 0, 2'b11, 1, 0, 0, 0};
    tbl[6] = '{8'hFF, 0, 2'b11, 1, 0, 0, 0};

    // reset values
    repeat (3) step();
    chk("reset_valid", 32'(rx_valid), 0);
    chk("reset_count", 32'(fifo_count), 0);
    chk("reset_data", 32'(rx_data), 0);
    chk("reset_pulses", 32'({parity_err, frame_err, overrun}), 0);
    rst_n = 1'b1;
    idle(2);

    // table-driven single frames
    for (int i = 0; i < 7; i++) begin
      clear_cnt();
      send_frame(tbl[i].data, tbl[i].flip, tbl[i].stops, 0);
      idle(2);
      chk("tbl_perr", 32'(perr_cnt), 32'(tbl[i].exp_perr));
      chk("tbl_ferr", 32'(ferr_cnt), 32'(tbl[i].exp_ferr));
      chk("tbl_both", 32'(both_cnt), 32'(tbl[i].exp_both));
      chk("tbl_ovr", 32'(ovr_cnt), 0);
      chk("tbl_count", 32'(fifo_count), 32'(tbl[i].exp_count));
      if (tbl[i].exp_count > 0) begin
        chk("tbl_valid", 32'(rx_valid), 1);
        chk("tbl_data", 32'(rx_data), 32'(tbl[i].data));
        pop_one();
        chk("tbl_drained", 32'(fifo_count), 0);
      end
    end

    // break: second stop bit low, line held low for a long time
    clear_cnt();
    send_frame(8'h3C, 0, 2'b01, 1);
    idle(20);
    chk("brk_ferr", 32'(ferr_cnt), 1);
    chk("brk_perr", 32'(perr_cnt), 0);
    chk("brk_count", 32'(fifo_count), 0);
    rx = 1'b1;
    idle(2);
    chk("brk_ferr_after", 32'(ferr_cnt), 1);
    send_frame(8'h3C, 0, 2'b11, 0);
    idle(2);
    chk("brk_recover_count", 32'(fifo_count), 1);
    chk("brk_recover_data", 32'(rx_data), 32'h3C);
    pop_one();

    // short glitch on idle line
    clear_cnt();
    rx = 1'b0;
    repeat (3) step();
    rx = 1'b1;
    idle(3);
    chk("glitch_count", 32'(fifo_count), 0);
    chk("glitch_pulses", 32'(perr_cnt + ferr_cnt + ovr_cnt), 0);

    // overrun: five frames into a four-entry FIFO with no consumer
    clear_cnt();
    for (int v = 1; v <= 5; v++) begin
      send_frame(8'(v), 0, 2'b11, 0);
      idle(1);
    end
    chk("ovr_count", 32'(fifo_count), 4);
    chk("ovr_pulses", 32'(ovr_cnt), 1);
    for (int v = 1; v <= 4; v++) begin
      chk("ovr_valid", 32'(rx_valid), 1);
      chk("ovr_data", 32'(rx_data), 32'(v));
      pop_one();
    end
    chk("ovr_empty", 32'(fifo_count), 0);
    chk("ovr_valid_low", 32'(rx_valid), 0);

    // reset in the middle of data bit 4 of 0x0F, with a word in the FIFO
    send_frame(8'h77, 0, 2'b11, 0);
    idle(1);
    chk("rst_pre_count", 32'(fifo_count), 1);
    clear_cnt();
    rx = 1'b0;
    repeat (BIT) step();
    for (int b = 0; b < 4; b++) begin
      rx = 1'b1;
      repeat (BIT) step();
    end
    rx = 1'b0;
    repeat (20) step();
    rst_n = 1'b0;
    repeat (5) step();
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_data", 32'(rx_data), 0);
    chk("rst_pulses", 32'({parity_err, frame_err, overrun}), 0);
    rst_n = 1'b1;
    repeat (BIT - 25 + 4 * BIT) step();
    rx = 1'b1;
    idle(3);
    chk("rst_after_count", 32'(fifo_count), 0);
    chk("rst_after_pulses", 32'(perr_cnt + ferr_cnt + ovr_cnt), 0);
    send_frame(8'hC3, 0, 2'b11, 0);
    idle(2);
    chk("rst_next_count", 32'(fifo_count), 1);
    chk("rst_next_data", 32'(rx_data), 32'hC3);
    pop_one();

    // random frames against a frame-level model with a random consumer
    clear_cnt();
    exp_perr = 0; exp_ferr = 0; exp_both = 0;
    rnd_mode = 1;
    for (int n = 0; n < 25; n++) begin
      logic [7:0] d;
      bit         fl;
      bit [1:0]   st;
      int         r;
      d  = 8'($urandom_range(0, 255));
      fl = ($urandom_range(0, 3) == 0);
      r  = int'($urandom_range(0, 7));
      st = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r == 2) ? 2'b10 : 2'b11;
      if (fl) exp_perr++;
      if (st != 2'b11) exp_ferr++;
      if (fl && st != 2'b11) exp_both++;
      if (!fl && st == 2'b11) exp_q.push_back(d);
      send_frame(d, fl, st, 0);
      idle(int'($urandom_range(1, 3)));
    end
    budget = 0;
    while (exp_q.size() != 0 && budget < 500) begin
      step();
      budget++;
    end
    rnd_mode = 0;
    rx_ready = 1'b0;
    step();
    chk("rnd_drain", 32'(exp_q.size()), 0);
    chk("rnd_perr", 32'(perr_cnt), 32'(exp_perr));
    chk("rnd_ferr", 32'(ferr_cnt), 32'(exp_ferr));
    chk("rnd_both", 32'(both_cnt), 32'(exp_both));
    chk("rnd_ovr", 32'(ovr_cnt), 0);
    chk("rnd_count", 32'(fifo_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
